// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Receive-side controller between a UART receiver and the system bus.
//   - Captures each completed frame into a DEPTH-entry show-ahead FIFO
//     that is drained through a valid/ready port.
//   - Counts receive errors and FIFO overflows in saturating 8-bit counters.
//   - Holds the receiver in reset while disabled. After an error it pulses
//     the receiver reset for RST_CYCLES cycles.
//
// State table
//   OFF     | receiver held in reset, frame/error edges ignored
//   RUN     | receiver active, completed frames pushed, errors counted
//   RECOVER | receiver held in reset for RST_CYCLES cycles after an error
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_enable       1 = receive, 0 = hold receiver in reset
//   i_rx_data      receiver data byte, stable while i_rx_done is high
//   i_rx_done      receiver frame-done level
//   i_rx_error     receiver error level, sticky until receiver idles
//   o_rx_rst       active-high reset to the receiver
//   o_m_data       FIFO head byte
//   o_m_valid      FIFO non-empty
//   i_m_ready      consumer accepts the head byte
//   o_fifo_count   FIFO occupancy, 0..DEPTH
//   o_err_cnt      error edges seen in RUN, saturating
//   o_ovf_cnt      frames dropped on a full FIFO, saturating
//   i_clr_cnt      synchronous clear of both counters
//   o_state        0=OFF, 1=RUN, 2=RECOVER
module uart_rx_ctrl #(
    parameter int DEPTH      = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_done,
    input  logic                     i_rx_error,
    output logic                     o_rx_rst,
    output logic [7:0]               o_m_data,
    output logic                     o_m_valid,
    input  logic                     i_m_ready,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic [7:0]               o_err_cnt,
    output logic [7:0]               o_ovf_cnt,
    input  logic                     i_clr_cnt,
    output logic [1:0]               o_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // The timer holds RST_CYCLES-1 down to 0, so it needs clog2(RST_CYCLES) bits.
    localparam int TW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rx_rst;
    logic            r_done_q;
    logic            r_err_q;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_err_cnt;
    logic [7:0]      r_ovf_cnt;

    logic            w_done_rise;
    logic            w_err_rise;
    logic            w_push_req;
    logic            w_err_hit;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_ovf;

    assign w_done_rise = i_rx_done & ~r_done_q;
    assign w_err_rise  = i_rx_error & ~r_err_q;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_push_req  = 1'b0;
        w_err_hit   = 1'b0;
        case (r_state)
            OFF: begin
                if (i_enable) w_state_nxt = RUN;
            end
            RUN: begin
                w_push_req = w_done_rise;
                if (!i_enable) begin
                    w_state_nxt = OFF;
                end else if (w_err_rise) begin
                    w_state_nxt = RECOVER;
                    w_err_hit   = 1'b1;
                    w_timer_nxt = TW'(RST_CYCLES - 1);
                end
            end
            RECOVER: begin
                if (r_timer == '0) begin
                    w_state_nxt = i_enable ? RUN : OFF;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: w_state_nxt = OFF;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= OFF;
            r_rx_rst <= 1'b1;
            r_timer  <= '0;
            r_done_q <= 1'b0;
            r_err_q  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rx_rst <= (w_state_nxt != RUN);
            r_timer  <= w_timer_nxt;
            r_done_q <= i_rx_done;
            r_err_q  <= i_rx_error;
        end
    end

    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    assign w_pop     = (r_count != '0) & i_m_ready;
    assign w_push_ok = w_push_req & ((r_count < CW'(DEPTH)) | w_pop);
    assign w_ovf     = w_push_req & ~w_push_ok;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_rx_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_err_cnt <= 8'd0;
            r_ovf_cnt <= 8'd0;
        end else begin
            if (i_clr_cnt)                        r_err_cnt <= 8'd0;
            else if (w_err_hit && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (i_clr_cnt)                        r_ovf_cnt <= 8'd0;
            else if (w_ovf && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign o_rx_rst     = r_rx_rst;
    assign o_m_data     = r_mem[r_rd_ptr];
    assign o_m_valid    = (r_count != '0);
    assign o_fifo_count = r_count;
    assign o_err_cnt    = r_err_cnt;
    assign o_ovf_cnt    = r_ovf_cnt;
    assign o_state      = r_state;

endmodule
